// File: rtl/sdram_arbiter.sv
`timescale 1ns/1ps
// sdram_arbiter
// Shares one SDRAM command/address/data bus between the power-up init
// module, the auto-refresh module and the write and read burst modules.
// Also owns the auto-refresh interval timer that raises o_ref_rq.
//
// Handshake: a client holds its request (i_wr_rq / i_rd_rq, or o_ref_rq for
// refresh) as a level until it sees its one-cycle grant pulse
// (o_wr_en / o_rd_en / o_ref_en). That pulse is high in the first cycle the
// client owns the bus. The client drives its bus inputs while it owns the bus
// and releases ownership with a one-cycle end pulse (i_wr_end_flag /
// i_rd_end_flag / i_ref_end). The arbiter never latches requests.
//
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_init_end                   init sequence complete (level)
//   i_init_cmd, i_init_addr      init module bus drive
//   i_ref_end                    refresh sequence done (pulse)
//   i_ref_cmd, i_ref_addr        refresh module bus drive
//   i_wr_rq, i_rd_rq             write / read requests (level)
//   i_wr_end_flag, i_rd_end_flag write / read burst done (pulse)
//   i_wr_cmd, i_wr_addr, i_wr_bank_addr, i_wr_data   write module bus drive
//   i_rd_cmd, i_rd_addr, i_rd_bank_addr              read module bus drive
//   o_ref_rq                     refresh pending
//   o_ref_en, o_wr_en, o_rd_en   one-cycle grant pulses
//   o_sdram_cmd/addr/bank        muxed SDRAM command {cs_n,ras_n,cas_n,we_n}
//   o_sdram_dq_out, o_sdram_dq_oe  write data and tristate enable
//   o_state                      debug: 0 INIT, 1 ARBIT, 2 AREF, 3 WRITE, 4 READ
module sdram_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 12,
    parameter int REF_PERIOD = 390
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_init_end,
    input  logic [3:0]            i_init_cmd,
    input  logic [ADDR_WIDTH-1:0] i_init_addr,
    input  logic                  i_ref_end,
    input  logic [3:0]            i_ref_cmd,
    input  logic [ADDR_WIDTH-1:0] i_ref_addr,
    input  logic                  i_wr_rq,
    input  logic                  i_rd_rq,
    input  logic                  i_wr_end_flag,
    input  logic                  i_rd_end_flag,
    input  logic [3:0]            i_wr_cmd,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [1:0]            i_wr_bank_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic [3:0]            i_rd_cmd,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    input  logic [1:0]            i_rd_bank_addr,
    output logic                  o_ref_rq,
    output logic                  o_ref_en,
    output logic                  o_wr_en,
    output logic                  o_rd_en,
    output logic [3:0]            o_sdram_cmd,
    output logic [ADDR_WIDTH-1:0] o_sdram_addr,
    output logic [1:0]            o_sdram_bank,
    output logic [DATA_WIDTH-1:0] o_sdram_dq_out,
    output logic                  o_sdram_dq_oe,
    output logic [2:0]            o_state
);

    localparam int         CNT_W   = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;
    localparam logic [3:0] CMD_NOP = 4'b0111;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_ARBIT = 3'd1,
        ST_AREF  = 3'd2,
        ST_WRITE = 3'd3,
        ST_READ  = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_ref_cnt;
    logic               r_ref_rq;
    logic               r_last_wr;   // 1: last wr/rd grant went to WRITE
    logic               r_ref_en;
    logic               r_wr_en;
    logic               r_rd_en;
    logic               w_ref_expire;

    assign w_ref_expire = i_init_end && (r_ref_cnt == CNT_W'(REF_PERIOD - 1));

    // Refresh interval timer: idle at 0 until init completes, then free-running.
    always_ff @(posedge i_clk) begin
        if (i_rst || !i_init_end) begin
            r_ref_cnt <= '0;
        end else if (w_ref_expire) begin
            r_ref_cnt <= '0;
        end else begin
            r_ref_cnt <= r_ref_cnt + CNT_W'(1);
        end
    end

    // Expiry wins over a coinciding ref_end; an expiry while already pending
    // simply keeps the flag high, so at most one refresh is ever owed.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ref_rq <= 1'b0;
        end else if (w_ref_expire) begin
            r_ref_rq <= 1'b1;
        end else if (i_ref_end) begin
            r_ref_rq <= 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_next;
        end
    end

    // Every grant is issued from ARBIT and every owner returns to ARBIT,
    // so at least one ARBIT cycle separates consecutive grants.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_INIT: begin
                if (i_init_end) w_next = ST_ARBIT;
            end
            ST_ARBIT: begin
                if (r_ref_rq) begin
                    w_next = ST_AREF;
                end else if (i_wr_rq && i_rd_rq) begin
                    w_next = r_last_wr ? ST_READ : ST_WRITE;
                end else if (i_wr_rq) begin
                    w_next = ST_WRITE;
                end else if (i_rd_rq) begin
                    w_next = ST_READ;
                end
            end
            ST_AREF: begin
                if (i_ref_end) w_next = ST_ARBIT;
            end
            ST_WRITE: begin
                if (i_wr_end_flag) w_next = ST_ARBIT;
            end
            ST_READ: begin
                if (i_rd_end_flag) w_next = ST_ARBIT;
            end
            default: w_next = ST_INIT;
        endcase
    end

    // Grant pulses are registered from the ARBIT decision, so they line up
    // with the first cycle spent in the granted state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ref_en  <= 1'b0;
            r_wr_en   <= 1'b0;
            r_rd_en   <= 1'b0;
            r_last_wr <= 1'b0;
        end else begin
            r_ref_en <= (r_state == ST_ARBIT) && (w_next == ST_AREF);
            r_wr_en  <= (r_state == ST_ARBIT) && (w_next == ST_WRITE);
            r_rd_en  <= (r_state == ST_ARBIT) && (w_next == ST_READ);
            if ((r_state == ST_ARBIT) && (w_next == ST_WRITE)) begin
                r_last_wr <= 1'b1;
            end else if ((r_state == ST_ARBIT) && (w_next == ST_READ)) begin
                r_last_wr <= 1'b0;
            end
        end
    end

    // Bus mux follows the current owner with no added latency. While reset is
    // asserted the bus is parked on NOP regardless of what init drives.
    always_comb begin
        o_sdram_cmd    = CMD_NOP;
        o_sdram_addr   = '0;
        o_sdram_bank   = 2'b00;
        o_sdram_dq_out = '0;
        o_sdram_dq_oe  = 1'b0;
        if (!i_rst) begin
            case (r_state)
                ST_INIT: begin
                    o_sdram_cmd  = i_init_cmd;
                    o_sdram_addr = i_init_addr;
                end
                ST_AREF: begin
                    o_sdram_cmd  = i_ref_cmd;
                    o_sdram_addr = i_ref_addr;
                end
                ST_WRITE: begin
                    o_sdram_cmd    = i_wr_cmd;
                    o_sdram_addr   = i_wr_addr;
                    o_sdram_bank   = i_wr_bank_addr;
                    o_sdram_dq_out = i_wr_data;
                    o_sdram_dq_oe  = 1'b1;
                end
                ST_READ: begin
                    o_sdram_cmd  = i_rd_cmd;
                    o_sdram_addr = i_rd_addr;
                    o_sdram_bank = i_rd_bank_addr;
                end
                default: ;
            endcase
        end
    end

    assign o_ref_rq = r_ref_rq;
    assign o_ref_en = r_ref_en;
    assign o_wr_en  = r_wr_en;
    assign o_rd_en  = r_rd_en;
    assign o_state  = r_state;

endmodule

// File: tb/tb_sdram_arbiter.sv
`timescale 1ns/1ps
module tb_sdram_arbiter;

    localparam int         DW  = 16;
    localparam int         AW  = 12;
    localparam int         P   = 10;
    localparam logic [3:0] NOP = 4'b0111;

    // Bus owner codes; they match the debug state output encoding.
    localparam int OWN_INIT = 0;
    localparam int OWN_IDLE = 1;
    localparam int OWN_REF  = 2;
    localparam int OWN_WR   = 3;
    localparam int OWN_RD   = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic          init_end = 1'b0;
    logic [3:0]    init_cmd, ref_cmd, wr_cmd, rd_cmd;
    logic [AW-1:0] init_addr, ref_addr, wr_addr, rd_addr;
    logic [1:0]    wr_bank_addr, rd_bank_addr;
    logic [DW-1:0] wr_data;
    logic          ref_end = 1'b0;
    logic          wr_rq = 1'b0, rd_rq = 1'b0;
    logic          wr_end_flag = 1'b0, rd_end_flag = 1'b0;

    logic          o_ref_rq, o_ref_en, o_wr_en, o_rd_en, o_sdram_dq_oe;
    logic [3:0]    o_sdram_cmd;
    logic [AW-1:0] o_sdram_addr;
    logic [1:0]    o_sdram_bank;
    logic [DW-1:0] o_sdram_dq_out;
    logic [2:0]    o_state;

    sdram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .REF_PERIOD(P)) dut (
        .i_clk(clk), .i_rst(rst), .i_init_end(init_end),
        .i_init_cmd(init_cmd), .i_init_addr(init_addr),
        .i_ref_end(ref_end), .i_ref_cmd(ref_cmd), .i_ref_addr(ref_addr),
        .i_wr_rq(wr_rq), .i_rd_rq(rd_rq),
        .i_wr_end_flag(wr_end_flag), .i_rd_end_flag(rd_end_flag),
        .i_wr_cmd(wr_cmd), .i_wr_addr(wr_addr), .i_wr_bank_addr(wr_bank_addr),
        .i_wr_data(wr_data),
        .i_rd_cmd(rd_cmd), .i_rd_addr(rd_addr), .i_rd_bank_addr(rd_bank_addr),
        .o_ref_rq(o_ref_rq), .o_ref_en(o_ref_en), .o_wr_en(o_wr_en), .o_rd_en(o_rd_en),
        .o_sdram_cmd(o_sdram_cmd), .o_sdram_addr(o_sdram_addr), .o_sdram_bank(o_sdram_bank),
        .o_sdram_dq_out(o_sdram_dq_out), .o_sdram_dq_oe(o_sdram_dq_oe),
        .o_state(o_state)
    );

    // ---------------- scoreboard / counters ----------------
    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc      = 0;
    logic [2:0] exp_q[$];
    bit         sb_on = 0;
    bit         sb_wrrd_only = 0;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    // Owner of the bus, edges counted since init completed, pending refresh,
    // fairness memory and the grant issued on the latest edge.
    int m_own     = OWN_INIT;
    int m_n       = 0;
    bit m_ref     = 0;
    bit m_last_wr = 0;
    int m_gnt     = 0;

    function automatic void model_edge();
        int nxt;
        if (rst) begin
            m_own = OWN_INIT; m_n = 0; m_ref = 0; m_last_wr = 0; m_gnt = 0;
            return;
        end
        nxt = m_own;
        if (m_own == OWN_INIT && init_end) nxt = OWN_IDLE;
        else if (m_own == OWN_IDLE) begin
            if (m_ref)               nxt = OWN_REF;
            else if (wr_rq && rd_rq) nxt = m_last_wr ? OWN_RD : OWN_WR;
            else if (wr_rq)          nxt = OWN_WR;
            else if (rd_rq)          nxt = OWN_RD;
        end
        else if (m_own == OWN_REF && ref_end)     nxt = OWN_IDLE;
        else if (m_own == OWN_WR  && wr_end_flag) nxt = OWN_IDLE;
        else if (m_own == OWN_RD  && rd_end_flag) nxt = OWN_IDLE;
        m_gnt = (m_own == OWN_IDLE && nxt != OWN_IDLE) ? nxt : 0;
        if (m_gnt == OWN_WR) m_last_wr = 1;
        if (m_gnt == OWN_RD) m_last_wr = 0;
        // Every P-th edge after init completes is a timer expiry.
        if (init_end) begin
            m_n++;
            if (m_n % P == 0) m_ref = 1;
            else if (ref_end) m_ref = 0;
        end else begin
            m_n = 0;
            if (ref_end) m_ref = 0;
        end
        m_own = nxt;
    endfunction

    task automatic compare_all();
        logic [3:0]    e_cmd  = NOP;
        logic [AW-1:0] e_addr = '0;
        logic [1:0]    e_bank = 2'b00;
        logic [DW-1:0] e_dq   = '0;
        logic          e_oe   = 1'b0;
        if (!rst) begin
            case (m_own)
                OWN_INIT: begin e_cmd = init_cmd; e_addr = init_addr; end
                OWN_REF:  begin e_cmd = ref_cmd;  e_addr = ref_addr;  end
                OWN_WR:   begin e_cmd = wr_cmd; e_addr = wr_addr; e_bank = wr_bank_addr;
                                e_dq = wr_data; e_oe = 1'b1; end
                OWN_RD:   begin e_cmd = rd_cmd; e_addr = rd_addr; e_bank = rd_bank_addr; end
                default: ;
            endcase
        end
        check("state",    32'(o_state),        32'(m_own));
        check("ref_rq",   32'(o_ref_rq),       32'(m_ref));
        check("ref_en",   32'(o_ref_en),       32'(m_gnt == OWN_REF));
        check("wr_en",    32'(o_wr_en),        32'(m_gnt == OWN_WR));
        check("rd_en",    32'(o_rd_en),        32'(m_gnt == OWN_RD));
        check("cmd",      32'(o_sdram_cmd),    32'(e_cmd));
        check("addr",     32'(o_sdram_addr),   32'(e_addr));
        check("bank",     32'(o_sdram_bank),   32'(e_bank));
        check("dq_out",   32'(o_sdram_dq_out), 32'(e_dq));
        check("dq_oe",    32'(o_sdram_dq_oe),  32'(e_oe));
    endtask

    // ---------------- client responders (driver side) ----------------
    bit auto_req  = 0;
    bit hold_req  = 0;
    int fixed_len = 2;
    bit ref_busy = 0, wr_busy = 0, rd_busy = 0;
    int ref_left = 0, wr_left = 0, rd_left = 0;

    function automatic int pick_len();
        return (fixed_len >= 0) ? fixed_len : int'($urandom_range(0, 5));
    endfunction

    task automatic respond();
        ref_end = 0; wr_end_flag = 0; rd_end_flag = 0;
        if (rst) begin
            ref_busy = 0; wr_busy = 0; rd_busy = 0;
            return;
        end
        if (o_ref_en) begin ref_busy = 1; ref_left = pick_len(); end
        if (o_wr_en)  begin wr_busy = 1; wr_left = pick_len(); wr_rq = hold_req; end
        if (o_rd_en)  begin rd_busy = 1; rd_left = pick_len(); rd_rq = hold_req; end
        if (ref_busy) begin if (ref_left == 0) begin ref_end = 1; ref_busy = 0; end else ref_left--; end
        if (wr_busy)  begin if (wr_left == 0) begin wr_end_flag = 1; wr_busy = 0; end else wr_left--; end
        if (rd_busy)  begin if (rd_left == 0) begin rd_end_flag = 1; rd_busy = 0; end else rd_left--; end
        if (auto_req) begin
            if (!wr_busy && !wr_rq && $urandom_range(0, 3) == 0) wr_rq = 1;
            if (!rd_busy && !rd_rq && $urandom_range(0, 3) == 0) rd_rq = 1;
            if (!ref_busy && !ref_end && $urandom_range(0, 24) == 0) ref_end = 1;
        end
    endtask

    task automatic randomize_bus();
        init_cmd = 4'($urandom); init_addr = AW'($urandom);
        ref_cmd  = 4'($urandom); ref_addr  = AW'($urandom);
        wr_cmd   = 4'($urandom); wr_addr   = AW'($urandom);
        rd_cmd   = 4'($urandom); rd_addr   = AW'($urandom);
        wr_bank_addr = 2'($urandom); rd_bank_addr = 2'($urandom);
        wr_data  = DW'($urandom);
    endtask

    task automatic step();
        logic [2:0] got;
        logic [2:0] e;
        randomize_bus();
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        compare_all();
        if (sb_on) begin
            got = o_ref_en ? 3'(OWN_REF) : o_wr_en ? 3'(OWN_WR) : o_rd_en ? 3'(OWN_RD) : 3'd0;
            if (got != 0 && !(sb_wrrd_only && got == 3'(OWN_REF))) begin
                if (exp_q.size() == 0) check("sb_unexpected_grant", 32'(got), 32'd0);
                else begin
                    e = exp_q.pop_front();
                    check("sb_grant_order", 32'(got), 32'(e));
                end
            end
        end
        respond();
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        int t;
        bit saw;
        randomize_bus();

        // Reset held 5 cycles; bus parked on NOP even though init drives junk.
        rst = 1;
        repeat (5) begin
            step();
            check("rst_state", 32'(o_state), 32'(OWN_INIT));
            check("rst_cmd_nop", 32'(o_sdram_cmd), 32'(NOP));
        end
        rst = 0;

        // INIT tracks init_cmd until init_end.
        while (cyc < 19) begin
            step();
            check("init_wait", 32'(o_state), 32'(OWN_INIT));
            check("init_cmd_track", 32'(o_sdram_cmd), 32'(init_cmd));
        end
        init_end = 1;
        step();
        check("init_to_arbit", 32'(o_state), 32'(OWN_IDLE));
        check("arbit_nop", 32'(o_sdram_cmd), 32'(NOP));

        // Refresh timing with no traffic.
        t = 1;
        while (!o_ref_rq && t < 30) begin step(); t++; end
        check("ref_rq_rise_delay", 32'(t), 32'd10);
        step();
        check("ref_en_pulse", 32'(o_ref_en), 32'd1);
        check("aref_state", 32'(o_state), 32'(OWN_REF));
        t = 0;
        while (o_ref_rq && t < 10) begin step(); t++; end
        check("ref_rq_fall", 32'(o_ref_rq), 32'd0);

        // ref_end coinciding with a timer expiry: set wins.
        t = 0;
        while (!(((m_n + 1) % P == 0) && !o_ref_rq && o_state == 3'(OWN_IDLE)) && t < 30) begin step(); t++; end
        ref_end = 1;
        step();
        check("ref_set_wins", 32'(o_ref_rq), 32'd1);

        // Collision: refresh, write and read all pending in one ARBIT cycle.
        t = 0;
        while (!(o_ref_rq == 0 && o_state == 3'(OWN_IDLE)) && t < 30) begin step(); t++; end
        t = 0;
        while (!o_ref_rq && t < 30) begin step(); t++; end
        check("collision_idle", 32'(o_state), 32'(OWN_IDLE));
        fixed_len = 0;
        wr_rq = 1; rd_rq = 1;
        sb_on = 1;
        exp_q.push_back(3'(OWN_REF)); exp_q.push_back(3'(OWN_WR)); exp_q.push_back(3'(OWN_RD));
        t = 0;
        while (exp_q.size() != 0 && t < 40) begin step(); t++; end
        check("collision_done", 32'(exp_q.size()), 32'd0);
        sb_on = 0;

        // Fairness: both held high across four grants.
        exp_q.delete();
        hold_req = 1; fixed_len = 1; sb_wrrd_only = 1; sb_on = 1;
        exp_q.push_back(3'(OWN_WR)); exp_q.push_back(3'(OWN_RD));
        exp_q.push_back(3'(OWN_WR)); exp_q.push_back(3'(OWN_RD));
        wr_rq = 1; rd_rq = 1;
        t = 0;
        while (exp_q.size() != 0 && t < 100) begin step(); t++; end
        check("fairness_done", 32'(exp_q.size()), 32'd0);
        sb_on = 0; sb_wrrd_only = 0; hold_req = 0;
        wr_rq = 0; rd_rq = 0;
        fixed_len = 2;
        t = 0;
        while (!(o_state == 3'(OWN_IDLE) && !o_ref_rq && !wr_busy && !rd_busy) && t < 60) begin step(); t++; end
        check("drain_idle", 32'(o_state), 32'(OWN_IDLE));

        // Refresh becomes due during a long write.
        exp_q.delete();
        fixed_len = 25;
        wr_rq = 1;
        t = 0;
        while (o_state != 3'(OWN_WR) && t < 30) begin step(); t++; end
        saw = 0;
        t = 0;
        while (o_state == 3'(OWN_WR) && t < 40) begin
            if (o_ref_rq) saw = 1;
            step(); t++;
        end
        check("ref_rose_in_write", 32'(saw), 32'd1);
        check("oe_drop_after_write", 32'(o_sdram_dq_oe), 32'd0);
        fixed_len = 2;
        sb_on = 1;
        exp_q.push_back(3'(OWN_REF));
        t = 0;
        while (exp_q.size() != 0 && t < 5) begin step(); t++; end
        check("aref_after_write", 32'(exp_q.size()), 32'd0);
        sb_on = 0;
        t = 0;
        while (!(o_state == 3'(OWN_IDLE) && !o_ref_rq) && t < 30) begin step(); t++; end

        // Reset in the middle of a read burst.
        fixed_len = 20;
        rd_rq = 1;
        t = 0;
        while (o_state != 3'(OWN_RD) && t < 30) begin step(); t++; end
        repeat (3) step();
        rst = 1; init_end = 0;
        step();
        check("rst_mid_read_state", 32'(o_state), 32'(OWN_INIT));
        check("rst_mid_read_cmd", 32'(o_sdram_cmd), 32'(NOP));
        check("rst_mid_read_ref_rq", 32'(o_ref_rq), 32'd0);
        rst = 0;
        rd_rq = 1;
        repeat (6) begin
            step();
            check("no_rd_en_before_init", 32'(o_rd_en), 32'd0);
        end
        init_end = 1;
        step();
        check("reinit_arbit", 32'(o_state), 32'(OWN_IDLE));
        step();
        check("regrant_read", 32'(o_rd_en), 32'd1);

        // Randomized traffic against the model.
        fixed_len = -1;
        auto_req = 1;
        repeat (2000) step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
